// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states and constants for the LDM/STM sequencer; WB state exists only with LDM_STM_WRITEBACK_EN
package cpu_pkg;

  localparam logic [3:0] PC_SELECT  = 4'd15;
  localparam int         WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
`ifdef LDM_STM_WRITEBACK_EN
    WB   = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/priority_enc16.sv
// rtl/priority_enc16.sv - lowest set bit of a 16-bit mask to a 4-bit index plus valid
module priority_enc16
  import cpu_pkg::*;
(
  input  logic [15:0] i_mask,
  output logic [3:0]  o_idx,
  output logic        o_valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = 4'd0;
    o_valid = 1'b0;
    for (int i = int'(PC_SELECT); i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM multi-register transfer sequencer; base writeback enabled by LDM_STM_WRITEBACK_EN
module ldm_stm_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       reg_list,
  output logic [3:0]        read_B_select,
  output logic              read_B_en,
  input  logic [31:0]       read_B_data,
  output logic [3:0]        write_select,
  output logic              write_en,
  output logic [31:0]       write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] L_STEP = ADDR_W'(WORD_BYTES);

  state_t            r_state, w_next;
  logic              r_is_load;
  logic [15:0]       r_mask;
  logic [ADDR_W-1:0] r_addr;

  logic [4:0]        w_n;
  logic [ADDR_W-1:0] w_span, w_first;
  logic [3:0]        w_idx;
  logic              w_valid, w_beat, w_last;
  logic [15:0]       w_mask_rest;

  assign w_n         = popcount16(reg_list);
  assign w_span      = ADDR_W'(w_n) * L_STEP;
  assign w_mask_rest = r_mask & (r_mask - 16'd1);
  assign w_last      = (w_mask_rest == 16'd0);
  assign w_beat      = (r_state == XFER) && w_valid && mem_ack;

  priority_enc16 u_penc (
    .i_mask  (r_mask),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Beats always walk upwards, so a descending transfer starts at the low end.
  always_comb begin
    w_first = base_addr;
    case ({up, pre})
      2'b11:   w_first = base_addr + L_STEP;
      2'b10:   w_first = base_addr;
      2'b01:   w_first = base_addr - w_span;
      default: w_first = base_addr - w_span + L_STEP;
    endcase
  end

`ifdef LDM_STM_WRITEBACK_EN
  logic              r_wb_active;
  logic [3:0]        r_base_reg;
  logic [ADDR_W-1:0] r_wb_val;
  logic              w_wb_req;
  logic [ADDR_W-1:0] w_wb_val;

  // A load that includes the base register keeps the loaded value.
  assign w_wb_req = writeback && !(is_load && reg_list[base_reg]);
  assign w_wb_val = up ? (base_addr + w_span) : (base_addr - w_span);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_active <= 1'b0;
      r_base_reg  <= 4'd0;
      r_wb_val    <= '0;
    end else if (r_state == IDLE && start) begin
      r_wb_active <= w_wb_req;
      r_base_reg  <= base_reg;
      r_wb_val    <= w_wb_val;
    end
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{writeback, base_reg};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_load <= 1'b0;
      r_mask    <= 16'd0;
      r_addr    <= '0;
    end else if (r_state == IDLE && start) begin
      r_is_load <= is_load;
      r_mask    <= reg_list;
      r_addr    <= w_first;
    end else if (w_beat) begin
      r_mask    <= w_mask_rest;
      r_addr    <= r_addr + L_STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Outputs are gated by reset so they drop in the same instant reset rises.
  always_comb begin
    w_next        = r_state;
    read_B_select = 4'd0;
    read_B_en     = 1'b0;
    write_select  = 4'd0;
    write_en      = 1'b0;
    write_data    = 32'd0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = 32'd0;
    busy          = 1'b0;
    done          = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (start) w_next = (reg_list == 16'd0) ? DONE : XFER;
        end
        XFER: begin
          busy     = 1'b1;
          mem_req  = w_valid;
          mem_we   = !r_is_load;
          mem_addr = r_addr;
          if (!r_is_load) begin
            read_B_en     = 1'b1;
            read_B_select = w_idx;
            mem_wdata     = read_B_data;
          end else if (w_beat) begin
            write_en     = 1'b1;
            write_select = w_idx;
            write_data   = mem_rdata;
          end
          if (w_beat && w_last) begin
`ifdef LDM_STM_WRITEBACK_EN
            w_next = r_wb_active ? WB : DONE;
`else
            w_next = DONE;
`endif
          end
        end
`ifdef LDM_STM_WRITEBACK_EN
        WB: begin
          busy         = 1'b1;
          write_en     = 1'b1;
          write_select = r_base_reg;
          write_data   = 32'(r_wb_val);
          w_next       = DONE;
        end
`endif
        DONE: begin
          done   = 1'b1;
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule
